fp32_norm_round_sched: RTL and testbench

//  Shares one combinational fp32 normalizer/rounder among NUM_REQ adder-tree lanes.

---
 rtl/fp32_norm_round_sched.sv | 139 +++++++++++++
 tb/tb_fp32_norm_round_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_norm_round_sched.sv
// Round-robin scheduler sharing one combinational fp32 normalizer/rounder among NUM_REQ lanes.
// Two-stage pipeline: issue register drives the rounder, result register holds the packed result.
module fp32_norm_round_sched #(
    parameter int NUM_REQ  = 4,
    parameter int IN_WIDTH = 32,
    parameter int ID_W     = 2,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_mant,
    input  logic [NUM_REQ*8-1:0]        req_exp,
    input  logic [NUM_REQ-1:0]          req_sign,
    input  logic                        cfg_dtz_en,
    output logic [IN_WIDTH-1:0]         nr_mant_raw,
    output logic [7:0]                  nr_exp,
    output logic                        nr_sign,
    output logic                        nr_dtz_en,
    input  logic [31:0]                 nr_fp_out,
    input  logic                        nr_ovf,
    input  logic                        nr_unf,
    input  logic                        nr_zero,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [31:0]                 res_data,
    output logic [ID_W-1:0]             res_id,
    output logic [2:0]                  res_flags,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            ovf_cnt,
    output logic [CNT_W-1:0]            unf_cnt
);

    typedef struct packed {
        logic [IN_WIDTH-1:0] mant;
        logic [7:0]          exp;
        logic                sign;
        logic                dtz;
        logic [ID_W-1:0]     id;
    } s1_t;

    s1_t             s1;
    logic            s1_valid;
    logic [ID_W-1:0] rr_ptr;
    logic            s2_load, s1_adv, s1_load;
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [2*NUM_REQ-1:0] rot2;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        sum;
    logic            res_hs;

    assign s2_load = !res_valid || res_ready;
    assign s1_adv  = s1_valid && s2_load;
    assign s1_load = !s1_valid || s1_adv;
    assign res_hs  = res_valid && res_ready;

    // Rotate request vector so bit 0 is the lane at rr_ptr; lowest set bit wins.
    assign rot2 = {req_valid, req_valid} >> rr_ptr;
    assign rot  = rot2[NUM_REQ-1:0];

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_vld = 1'b1;
                sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
                if (sum >= (ID_W + 1)'(NUM_REQ))
                    sum = sum - (ID_W + 1)'(NUM_REQ);
                grant_id = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && s1_load && grant_vld)
            req_ready = NUM_REQ'(1) << grant_id;
    end

    wire do_grant = s1_load && grant_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s1_valid <= 1'b0;
            rr_ptr   <= '0;
        end else if (do_grant) begin
            s1.mant  <= req_mant[grant_id*IN_WIDTH +: IN_WIDTH];
            s1.exp   <= req_exp[grant_id*8 +: 8];
            s1.sign  <= req_sign[grant_id];
            s1.dtz   <= cfg_dtz_en;
            s1.id    <= grant_id;
            s1_valid <= 1'b1;
            rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_flags <= '0;
        end else if (s1_adv) begin
            res_valid <= 1'b1;
            res_data  <= nr_fp_out;
            res_id    <= s1.id;
            res_flags <= {nr_ovf, nr_unf, nr_zero};
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Clear wins over a coincident event; increments stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else if (res_hs) begin
            if (res_flags[2] && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + 1'b1;
            if (res_flags[1] && !(&unf_cnt)) unf_cnt <= unf_cnt + 1'b1;
        end
    end

    assign nr_mant_raw = s1.mant;
    assign nr_exp      = s1.exp;
    assign nr_sign     = s1.sign;
    assign nr_dtz_en   = s1.dtz;

endmodule

// File: tb/tb_fp32_norm_round_sched.sv
// Directed bench for fp32_norm_round_sched with a behavioural stand-in for the shared rounder.
module tb_fp32_norm_round_sched;
    localparam int NUM_REQ = 4, IN_WIDTH = 32, ID_W = 2, CNT_W = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0, req_ready, req_sign = '0;
    logic [NUM_REQ*IN_WIDTH-1:0] req_mant = '0;
    logic [NUM_REQ*8-1:0] req_exp = '0;
    logic cfg_dtz_en = 1'b0, res_ready = 1'b1, cnt_clr = 1'b0;
    logic [IN_WIDTH-1:0] nr_mant_raw;
    logic [7:0] nr_exp;
    logic nr_sign, nr_dtz_en, nr_ovf, nr_unf, nr_zero, res_valid;
    logic [31:0] nr_fp_out, res_data;
    logic [ID_W-1:0] res_id;
    logic [2:0] res_flags;
    logic [CNT_W-1:0] ovf_cnt, unf_cnt;

    int checks = 0, errors = 0, hs = 0;

    fp32_norm_round_sched #(.NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_mant(req_mant), .req_exp(req_exp), .req_sign(req_sign), .cfg_dtz_en(cfg_dtz_en),
        .nr_mant_raw(nr_mant_raw), .nr_exp(nr_exp), .nr_sign(nr_sign), .nr_dtz_en(nr_dtz_en),
        .nr_fp_out(nr_fp_out), .nr_ovf(nr_ovf), .nr_unf(nr_unf), .nr_zero(nr_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .res_flags(res_flags), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
    );

    always #5 clk = ~clk;

    // Truncating normalizer: value = m * 2^(e-150); returns {ovf,unf,zero,fp32}.
    function automatic logic [34:0] rnd(input logic [31:0] m, input logic [7:0] e, input logic s);
        int p, ex;
        logic [31:0] frac;
        if (m == 0) return {3'b001, s, 31'd0};
        p = 0;
        for (int b = 0; b < 32; b++) if (m[b]) p = b;
        ex = int'(e) + p - 23;
        if (ex >= 255) return {3'b100, s, 8'hFF, 23'd0};
        if (ex <= 0)   return {3'b010, s, 31'd0};
        frac = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
        return {3'b000, s, ex[7:0], frac[22:0]};
    endfunction

    always_comb {nr_ovf, nr_unf, nr_zero, nr_fp_out} = rnd(nr_mant_raw, nr_exp, nr_sign);

    function automatic logic [34:0] lane_res(input int i);
        logic [31:0] m;
        logic [7:0] e;
        m = req_mant[i*32 +: 32];
        e = req_exp[i*8 +: 8];
        return rnd(m, e, req_sign[i]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [31:0] m, input logic [7:0] e, input logic s);
        req_mant[i*32 +: 32] = m;
        req_exp[i*8 +: 8] = e;
        req_sign[i] = s;
    endtask

    task automatic default_lanes();
        for (int i = 0; i < NUM_REQ; i++)
            set_lane(i, 32'h0080_0000 + 32'(i * 'h111), 8'(8'h7F + i), i[0]);
    endtask

    logic [34:0] r;

    initial begin
        default_lanes();
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 0);
        check("rst_nr_mant", nr_mant_raw, 0);

        // Full-rate round robin across all four lanes
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            check("rr_res_valid", 32'(res_valid), (c >= 2) ? 1 : 0);
            if (c >= 2) begin
                r = lane_res((c - 2) % 4);
                check("rr_res_id", 32'(res_id), 32'((c - 2) % 4));
                check("rr_res_data", res_data, r[31:0]);
            end
            step();
        end
        req_valid = '0;
        step(); step(); step();

        // Golden value and zero flag
        set_lane(2, 32'h0080_0000, 8'h7F, 1'b0);
        req_valid = 4'b0100;
        #1 check("one_grant", 32'(req_ready), 4);
        step(); req_valid = '0; step();
        check("one_valid", 32'(res_valid), 1);
        check("one_data", res_data, 32'h3F80_0000);
        check("one_flags", 32'(res_flags), 0);
        check("one_id", 32'(res_id), 2);
        set_lane(2, 32'h0, 8'h7F, 1'b0);
        req_valid = 4'b0100;
        #1 check("zero_grant", 32'(req_ready), 4);
        step(); req_valid = '0; step();
        check("zero_data", res_data, 0);
        check("zero_flags", 32'(res_flags), 1);
        step();

        // Wrap of rr_ptr from 3 to 0
        req_valid = 4'b1000;
        #1 check("wrap_grant3", 32'(req_ready), 8);
        step(); req_valid = 4'b1001;
        #1 check("wrap_grant0", 32'(req_ready), 1);
        step(); req_valid = '0;
        #1 check("wrap_id3", 32'(res_id), 3);
        step();
        check("wrap_id0", 32'(res_id), 0);
        step();

        // Backpressure: two fills then freeze, drain in order
        default_lanes();
        req_valid = 4'hF; res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c == 0) check("bp_grant1", 32'(req_ready), 2);
            if (c == 1) check("bp_grant2", 32'(req_ready), 4);
            if (|(req_valid & req_ready)) hs++;
            step();
        end
        r = lane_res(1);
        check("bp_hs", 32'(hs), 2);
        check("bp_ready", 32'(req_ready), 0);
        check("bp_id", 32'(res_id), 1);
        check("bp_data", res_data, r[31:0]);
        res_ready = 1'b1; req_valid = '0;
        step();
        r = lane_res(2);
        check("bp_rel_valid", 32'(res_valid), 1);
        check("bp_rel_id", 32'(res_id), 2);
        check("bp_rel_data", res_data, r[31:0]);
        step();
        check("bp_empty", 32'(res_valid), 0);

        // cfg_dtz_en travels with the granted transaction
        req_valid = 4'b0001; cfg_dtz_en = 1'b1;
        step(); req_valid = '0; cfg_dtz_en = 1'b0;
        #1 check("dtz_set", 32'(nr_dtz_en), 1);
        step(); step();
        check("dtz_hold", 32'(nr_dtz_en), 1);
        req_valid = 4'b0001;
        step(); req_valid = '0;
        check("dtz_new", 32'(nr_dtz_en), 0);
        step(); step();

        // Underflow event
        set_lane(0, 32'h1, 8'h01, 1'b0);
        req_valid = 4'b0001;
        step(); req_valid = '0; step();
        check("unf_flags", 32'(res_flags), 2);
        check("unf_data", res_data, 0);
        step();
        check("unf_cnt", 32'(unf_cnt), 1);
        check("unf_ovf_cnt", 32'(ovf_cnt), 0);

        // Overflow counting and saturation over 2^16+1 events
        set_lane(0, 32'hFFFF_FFFF, 8'hFE, 1'b0);
        req_valid = 4'b0001;
        for (int n = 0; n < 10; n++) begin
            if (n == 2) begin
                check("ovf_flags", 32'(res_flags), 4);
                check("ovf_data", res_data, 32'h7F80_0000);
            end
            step();
        end
        req_valid = '0;
        step(); step(); step();
        check("ovf_cnt10", 32'(ovf_cnt), 10);
        req_valid = 4'b0001;
        for (int n = 0; n < 65527; n++) step();
        req_valid = '0;
        step(); step(); step();
        check("ovf_sat", 32'(ovf_cnt), 32'hFFFF);
        req_valid = 4'b0001;
        step(); req_valid = '0; step();
        check("ovf_sat_hold", 32'(ovf_cnt), 32'hFFFF);
        cnt_clr = 1'b1;
        step(); cnt_clr = 1'b0;
        check("clr_cnt", 32'(ovf_cnt), 0);
        step();
        check("clr_after", 32'(ovf_cnt), 0);

        // Asynchronous reset with both stages full
        default_lanes();
        req_valid = 4'hF; res_ready = 1'b0;
        step(); step();
        check("pre_rst_valid", 32'(res_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 0);
        check("arst_req_ready", 32'(req_ready), 0);
        check("arst_nr_mant", nr_mant_raw, 0);
        check("arst_unf_cnt", 32'(unf_cnt), 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("arst_rr_ptr", 32'(req_ready), 1);
        res_ready = 1'b1; req_valid = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
